// File: rtl/m14k_isp_arb.sv
// Arbiter/sequencer for the single ISPRAM port: fetch reads, icop index stores and
// loader writes share one registered command that is held across ISP_Stall.
module m14k_isp_arb #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        gclk,
   input  logic        greset,
   input  logic        cpz_spram,
   input  logic [8:0]  isp_size,
   input  logic        fetch_req,
   input  logic [17:0] fetch_addr,
   output logic        fetch_gnt,
   output logic        fetch_rvalid,
   output logic [31:0] fetch_rdata,
   input  logic        icop_req,
   input  logic [17:0] icop_addr,
   input  logic [31:0] icop_data,
   output logic        icop_ack,
   input  logic        ext_valid,
   input  logic [17:0] ext_addr,
   input  logic [31:0] ext_data,
   output logic        ext_ready,
   output logic        ext_err,
   input  logic        ISP_Stall,
   input  logic [31:0] ISP_DataRdValue,
   output logic [17:0] ISP_Addr,
   output logic [31:0] ISP_DataTagValue,
   output logic        ISP_RdStr,
   output logic        ISP_DataWrStr,
   output logic        isp_busy
);

   typedef enum logic {IDLE, CMD} state_e;
   typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_ICOP, OWN_EXT} owner_e;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_e      state, state_nx;
   owner_e      owner, owner_nx;
   logic [17:0] addr_q, addr_nx;
   logic [31:0] data_q, data_nx;
   logic        rd_q, rd_nx, wr_q, wr_nx;
   logic [3:0]  starve_cnt, starve_nx;
   logic        icop_ack_q, icop_ack_nx;
   logic        ext_ready_q, ext_ready_nx, ext_err_q, ext_err_nx;
   logic        rvalid_q;
   logic [31:0] rdata_q;

   logic accept, icop_v, ext_v, ext_ok, ext_win;

   assign accept = (state == CMD) && !ISP_Stall;
   // A requester whose early ack is still on the wire is still holding its request;
   // masking it here stops the same transaction being arbitrated twice.
   assign icop_v = icop_req && !icop_ack_q;
   assign ext_v  = ext_valid && !ext_ready_q;
   assign ext_ok = {1'b0, ext_addr[17:10]} < isp_size;

   // NOTE: every variable gets its default first so no path through the case can infer a latch.
   always_comb begin
      state_nx     = state;
      owner_nx     = owner;
      addr_nx      = addr_q;
      data_nx      = data_q;
      rd_nx        = rd_q;
      wr_nx        = wr_q;
      starve_nx    = starve_cnt;
      icop_ack_nx  = 1'b0;
      ext_ready_nx = 1'b0;
      ext_err_nx   = 1'b0;
      ext_win      = 1'b0;
      case (state)
         IDLE: begin
            if (icop_v) begin
               if (cpz_spram) begin
                  state_nx = CMD;  owner_nx = OWN_ICOP;
                  addr_nx  = icop_addr;  data_nx = icop_data;  wr_nx = 1'b1;
               end else begin
                  icop_ack_nx = 1'b1;
               end
            end else if (ext_v && starve_cnt == LIMIT) begin
               ext_win = 1'b1;
            end else if (fetch_req) begin
               state_nx = CMD;  owner_nx = OWN_FETCH;
               addr_nx  = fetch_addr;  data_nx = '0;  rd_nx = 1'b1;
            end else if (ext_v) begin
               ext_win = 1'b1;
            end
            if (ext_win) begin
               if (ext_ok) begin
                  state_nx = CMD;  owner_nx = OWN_EXT;
                  addr_nx  = ext_addr;  data_nx = ext_data;  wr_nx = 1'b1;
               end else begin
                  ext_ready_nx = 1'b1;
                  ext_err_nx   = 1'b1;
               end
            end
            if (!ext_v || ext_win)        starve_nx = '0;
            else if (starve_cnt != LIMIT) starve_nx = starve_cnt + 4'd1;
         end
         CMD: begin
            if (!ISP_Stall) begin
               state_nx = IDLE;
               rd_nx    = 1'b0;
               wr_nx    = 1'b0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge gclk) begin
      if (greset) begin
         state       <= IDLE;
         owner       <= OWN_NONE;
         addr_q      <= '0;
         data_q      <= '0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         starve_cnt  <= '0;
         icop_ack_q  <= 1'b0;
         ext_ready_q <= 1'b0;
         ext_err_q   <= 1'b0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state       <= state_nx;
         owner       <= owner_nx;
         addr_q      <= addr_nx;
         data_q      <= data_nx;
         rd_q        <= rd_nx;
         wr_q        <= wr_nx;
         starve_cnt  <= starve_nx;
         icop_ack_q  <= icop_ack_nx;
         ext_ready_q <= ext_ready_nx;
         ext_err_q   <= ext_err_nx;
         rvalid_q    <= accept && owner == OWN_FETCH;
         if (rvalid_q) rdata_q <= ISP_DataRdValue;
      end
   end

   // Read data is live from the RAM in the return cycle, then held locally.
   assign fetch_rdata      = rvalid_q ? ISP_DataRdValue : rdata_q;
   assign fetch_rvalid     = rvalid_q;
   assign fetch_gnt        = accept && owner == OWN_FETCH;
   assign icop_ack         = icop_ack_q || (accept && owner == OWN_ICOP);
   assign ext_ready        = ext_ready_q || (accept && owner == OWN_EXT);
   assign ext_err          = ext_err_q;
   assign ISP_Addr         = addr_q;
   assign ISP_DataTagValue = data_q;
   assign ISP_RdStr        = rd_q;
   assign ISP_DataWrStr    = wr_q;
   assign isp_busy         = state == CMD;

endmodule

// File: tb/tb_m14k_isp_arb.sv
// Scoreboard bench for m14k_isp_arb: expected RAM commands and read returns are queued
// as stimulus is driven and compared when the DUT accepts a command or returns data.
module tb_m14k_isp_arb;

   localparam int unsigned STARVE_LIMIT = 4;

   typedef struct packed {
      logic        wr;
      logic [17:0] addr;
      logic [31:0] data;
      logic [2:0]  ack;   // {fetch_gnt, icop_ack, ext_ready}
   } cmd_t;

   logic        gclk = 1'b0;
   logic        greset, cpz_spram;
   logic [8:0]  isp_size;
   logic        fetch_req, icop_req, ext_valid, ISP_Stall;
   logic [17:0] fetch_addr, icop_addr, ext_addr;
   logic [31:0] icop_data, ext_data, ISP_DataRdValue;
   logic        fetch_gnt, fetch_rvalid, icop_ack, ext_ready, ext_err;
   logic [31:0] fetch_rdata, ISP_DataTagValue;
   logic [17:0] ISP_Addr;
   logic        ISP_RdStr, ISP_DataWrStr, isp_busy;

   int   n_checks = 0;
   int   n_errors = 0;
   cmd_t cmd_q[$];
   logic [31:0] rd_q[$];
   logic        hold_prev;
   logic [51:0] prev_pins;

   m14k_isp_arb #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
      .gclk(gclk), .greset(greset), .cpz_spram(cpz_spram), .isp_size(isp_size),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
      .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
      .icop_req(icop_req), .icop_addr(icop_addr), .icop_data(icop_data), .icop_ack(icop_ack),
      .ext_valid(ext_valid), .ext_addr(ext_addr), .ext_data(ext_data),
      .ext_ready(ext_ready), .ext_err(ext_err),
      .ISP_Stall(ISP_Stall), .ISP_DataRdValue(ISP_DataRdValue), .ISP_Addr(ISP_Addr),
      .ISP_DataTagValue(ISP_DataTagValue), .ISP_RdStr(ISP_RdStr),
      .ISP_DataWrStr(ISP_DataWrStr), .isp_busy(isp_busy)
   );

   always #5 gclk = ~gclk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rd_model(input logic [17:0] a);
      return (a == 18'h00010) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
   endfunction

   // Synchronous RAM model: data follows an accepted read by one cycle.
   always @(posedge gclk)
      ISP_DataRdValue <= (ISP_RdStr && !ISP_Stall) ? rd_model(ISP_Addr) : 32'h5A5A0000;

   // Output monitor: scoreboard pops, strobe exclusivity, pin hold during stall.
   always @(negedge gclk) begin
      if (greset) begin
         hold_prev <= 1'b0;
      end else begin
         if (ISP_RdStr && ISP_DataWrStr) check("strobe_excl", 64'(1), 64'(0));
         if (hold_prev)
            check("stall_hold", 64'({ISP_RdStr, ISP_DataWrStr, ISP_Addr, ISP_DataTagValue}),
                  64'(prev_pins));
         if ((ISP_RdStr || ISP_DataWrStr) && !ISP_Stall) begin
            if (cmd_q.size() == 0) check("cmd_unexpected", 64'(1), 64'(0));
            else begin
               automatic cmd_t e = cmd_q.pop_front();
               check("cmd", 64'({ISP_DataWrStr, ISP_Addr, ISP_DataTagValue,
                                 fetch_gnt, icop_ack, ext_ready}), 64'(e));
            end
         end
         if (fetch_rvalid) begin
            if (rd_q.size() == 0) check("rvalid_unexpected", 64'(1), 64'(0));
            else check("rdata", 64'(fetch_rdata), 64'(rd_q.pop_front()));
         end
         hold_prev <= (ISP_RdStr || ISP_DataWrStr) && ISP_Stall;
         prev_pins <= {ISP_RdStr, ISP_DataWrStr, ISP_Addr, ISP_DataTagValue};
      end
   end

   task automatic cyc;   // step to just after the next rising edge
      @(posedge gclk);
      #1;
   endtask

   task automatic smp;   // sample point, away from the active edge
      @(negedge gclk);
   endtask

   task automatic push_cmd(input logic wr, input logic [17:0] a, input logic [31:0] d,
                           input logic [2:0] ack);
      automatic cmd_t c;
      c.wr = wr;  c.addr = a;  c.data = d;  c.ack = ack;
      cmd_q.push_back(c);
   endtask

   // Requesters drop their request on their own ack; bounded.
   task automatic serve(input int max_cyc);
      int c;
      for (c = 0; c < max_cyc && (fetch_req || icop_req || ext_valid); c++) begin
         smp();
         if (fetch_gnt) fetch_req = 1'b0;
         if (icop_ack)  icop_req  = 1'b0;
         if (ext_ready) ext_valid = 1'b0;
      end
      check("serve_timeout", 64'(fetch_req || icop_req || ext_valid), 64'(0));
      repeat (3) smp();
   endtask

   initial begin
      greset = 1'b1;  cpz_spram = 1'b1;  isp_size = 9'h1FF;  ISP_Stall = 1'b0;
      fetch_req = 1'b0;  icop_req = 1'b0;  ext_valid = 1'b0;
      fetch_addr = '0;  icop_addr = '0;  ext_addr = '0;  icop_data = '0;  ext_data = '0;
      repeat (3) cyc();
      greset = 1'b0;
      smp();
      check("rst_outputs", 64'({ISP_RdStr, ISP_DataWrStr, isp_busy, fetch_gnt, fetch_rvalid,
                                icop_ack, ext_ready, ext_err}), 64'(0));
      check("rst_pins", 64'({ISP_Addr, ISP_DataTagValue, fetch_rdata}), 64'(0));

      // Single fetch, no stall.
      cyc();
      fetch_req = 1'b1;  fetch_addr = 18'h00010;
      push_cmd(1'b0, 18'h00010, 32'h0, 3'b100);
      rd_q.push_back(32'hDEADBEEF);
      cyc();  smp();
      check("f1_issue", 64'({ISP_RdStr, fetch_gnt, isp_busy, ISP_Addr}), 64'({3'b111, 18'h00010}));
      fetch_req = 1'b0;
      smp();
      check("f1_ret", 64'({isp_busy, fetch_rvalid, fetch_rdata}), 64'({2'b01, 32'hDEADBEEF}));
      smp();
      check("f1_hold", 64'({fetch_rvalid, fetch_rdata}), 64'({1'b0, 32'hDEADBEEF}));

      // icop store with three stall cycles.
      cyc();
      icop_req = 1'b1;  icop_addr = 18'h00020;  icop_data = 32'h12345678;  ISP_Stall = 1'b1;
      push_cmd(1'b1, 18'h00020, 32'h12345678, 3'b010);
      cyc();
      for (int k = 1; k <= 4; k++) begin
         smp();
         check("icop_stall", 64'({ISP_DataWrStr, icop_ack, ISP_Addr, ISP_DataTagValue}),
               64'({1'b1, k == 4, 18'h00020, 32'h12345678}));
         if (k == 4) icop_req = 1'b0;
         else begin
            cyc();
            if (k == 3) ISP_Stall = 1'b0;
         end
      end
      smp();
      check("icop_done", 64'({ISP_DataWrStr, isp_busy, icop_ack}), 64'(0));

      // icop with cpz_spram=0: ack only.
      cyc();
      cpz_spram = 1'b0;  icop_req = 1'b1;  icop_addr = 18'h00024;
      cyc();  smp();
      check("icop_nospram", 64'({icop_ack, ISP_DataWrStr, isp_busy}), 64'(3'b100));
      icop_req = 1'b0;
      smp();
      check("icop_nospram_once", 64'({icop_ack, ISP_DataWrStr}), 64'(0));
      cpz_spram = 1'b1;

      // Loader starvation: fetch held continuously; ext wins after STARVE_LIMIT losses.
      for (int r = 0; r < 2; r++) begin
         automatic int n_f = 0;
         automatic bit got = 1'b0;
         cyc();
         fetch_req = 1'b1;  fetch_addr = 18'h00100;
         ext_valid = 1'b1;  ext_addr = 18'h00404;  ext_data = 32'hCAFE0000 + 32'(r);
         for (int i = 0; i < int'(STARVE_LIMIT); i++) begin
            push_cmd(1'b0, 18'h00100 + 18'(i), 32'h0, 3'b100);
            rd_q.push_back(rd_model(18'h00100 + 18'(i)));
         end
         push_cmd(1'b1, 18'h00404, 32'hCAFE0000 + 32'(r), 3'b001);
         for (int c = 0; c < 40 && !got; c++) begin
            smp();
            if (fetch_gnt) begin
               n_f++;
               fetch_addr = fetch_addr + 18'd1;
            end
            if (ext_ready) begin
               got = 1'b1;
               fetch_req = 1'b0;  ext_valid = 1'b0;
               check("starve_fetch_wins", 64'(n_f), 64'(STARVE_LIMIT));
               check("starve_cnt_clear", 64'(dut.starve_cnt), 64'(0));
            end
         end
         check("starve_timeout", 64'(got), 64'(1));
         repeat (3) smp();
      end

      // Range check with isp_size = 2 (8 KB).
      cyc();
      isp_size = 9'd2;  ext_valid = 1'b1;  ext_addr = 18'h00800;  ext_data = 32'h11112222;
      cyc();  smp();
      check("ext_oor", 64'({ext_ready, ext_err, ISP_DataWrStr, ISP_RdStr, isp_busy}), 64'(5'b11000));
      ext_valid = 1'b0;
      smp();
      check("ext_oor_once", 64'({ext_ready, ext_err}), 64'(0));
      cyc();
      ext_valid = 1'b1;  ext_addr = 18'h00405;  ext_data = 32'hA1B2C3D4;
      push_cmd(1'b1, 18'h00405, 32'hA1B2C3D4, 3'b001);
      cyc();  smp();
      check("ext_inrange", 64'({ext_ready, ext_err, ISP_DataWrStr}), 64'(3'b101));
      ext_valid = 1'b0;
      smp();
      cyc();
      isp_size = 9'd0;  ext_valid = 1'b1;  ext_addr = 18'h00000;
      cyc();  smp();
      check("ext_size0", 64'({ext_ready, ext_err, ISP_DataWrStr}), 64'(3'b110));
      ext_valid = 1'b0;
      smp();
      isp_size = 9'h1FF;

      // All three requesters together: icop, then fetch, then ext.
      cyc();
      icop_req  = 1'b1;  icop_addr = 18'h00030;  icop_data = 32'h0BADF00D;
      fetch_req = 1'b1;  fetch_addr = 18'h00040;
      ext_valid = 1'b1;  ext_addr = 18'h00408;  ext_data = 32'h55AA55AA;
      push_cmd(1'b1, 18'h00030, 32'h0BADF00D, 3'b010);
      push_cmd(1'b0, 18'h00040, 32'h0, 3'b100);
      push_cmd(1'b1, 18'h00408, 32'h55AA55AA, 3'b001);
      rd_q.push_back(rd_model(18'h00040));
      serve(30);

      // Reset while a stalled command is held.
      cyc();
      fetch_req = 1'b1;  fetch_addr = 18'h00050;  ext_valid = 1'b1;  ext_addr = 18'h00404;
      ISP_Stall = 1'b1;
      cyc();  smp();
      check("rst_pre_cmd", 64'({ISP_RdStr, fetch_gnt, isp_busy}), 64'(3'b101));
      check("rst_pre_cnt", 64'(dut.starve_cnt), 64'(1));
      cyc();
      greset = 1'b1;  fetch_req = 1'b0;  ext_valid = 1'b0;
      cyc();  smp();
      check("rst_cmd_drop", 64'({ISP_RdStr, ISP_DataWrStr, isp_busy, fetch_gnt, fetch_rvalid,
                                 icop_ack, ext_ready}), 64'(0));
      check("rst_cnt", 64'(dut.starve_cnt), 64'(0));
      cyc();
      greset = 1'b0;  ISP_Stall = 1'b0;
      for (int k = 0; k < 3; k++) begin
         smp();
         check("rst_no_ret", 64'({fetch_rvalid, ISP_RdStr, isp_busy}), 64'(0));
      end

      check("cmd_q_empty", 64'(cmd_q.size()), 64'(0));
      check("rd_q_empty", 64'(rd_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/m14k_isp_arb.md
Name: m14k_isp_arb

Overview:
Arbiter and sequencer for the single instruction-scratchpad RAM port (ISP_Addr/ISP_DataTagValue/ISP_RdStr/ISP_DataWrStr). It shares the port between three requesters: instruction-fetch reads, cache-op index stores (icop, gated by cpz_spram) and an external loader write channel (valid/ready). It registers the RAM command, holds it across ISP_Stall, returns fetch read data, and bounds loader starvation. It sits between the icc fetch/icop logic and the ISPRAM pins.

Parameters:
STARVE_LIMIT, 4, consecutive lost arbitrations after which a pending loader write beats fetch (range 1..15)

Ports:
gclk  in  1  core clock
greset  in  1  synchronous active-high reset
cpz_spram  in  1  icop stores target ISPRAM when 1
isp_size  in  9  ISPRAM size in 4 KB units (bits [20:12])
fetch_req  in  1  fetch read request (level)
fetch_addr  in  18  fetch word address [19:2]
fetch_gnt  out  1  pulse: fetch command accepted by RAM
fetch_rvalid  out  1  pulse: fetch_rdata valid
fetch_rdata  out  32  read data
icop_req  in  1  icop store request (level, held until ack)
icop_addr  in  18  icop word address [19:2]
icop_data  in  32  icop store data
icop_ack  out  1  pulse: icop store done
ext_valid  in  1  loader write valid
ext_addr  in  18  loader word address [19:2]
ext_data  in  32  loader write data
ext_ready  out  1  pulse: loader write consumed
ext_err  out  1  with ext_ready: address out of range, no write
ISP_Stall  in  1  RAM not accepting this cycle
ISP_DataRdValue  in  32  RAM read data
ISP_Addr  out  18  RAM word address
ISP_DataTagValue  out  32  RAM write data
ISP_RdStr  out  1  RAM read strobe
ISP_DataWrStr  out  1  RAM write strobe
isp_busy  out  1  command outstanding (IDLE not current)

Behaviour:
- Reset, clocked on gclk only: all outputs 0; state IDLE; starve_cnt 0; any held command or pending read return is discarded, so no rvalid follows.
- States: IDLE (no command), CMD (registered command on RAM pins).
- IDLE: arbitration runs on this cycle's requests. Winner's addr/data/strobe are registered and driven on the pins next cycle; state goes to CMD. No winner: strobes stay 0.
- Priority: icop > ext (starve_cnt==STARVE_LIMIT) > fetch > ext.
- icop with cpz_spram=0: no RAM command; icop_ack pulses next cycle; state stays IDLE.
- ext range check: ext_addr[19:12] zero-extended must be < isp_size. If it fails, and ext wins, there is no RAM command; ext_ready=1 and ext_err=1 next cycle; state stays IDLE. isp_size=0 rejects all ext.
- CMD acceptance: a cycle in CMD with ISP_Stall=0 accepts the command. In that cycle the matching fetch_gnt / icop_ack / ext_ready pulses. Next cycle strobes drop and state returns to IDLE.
- CMD with ISP_Stall=1: pins held bit-stable; no ack; no re-arbitration.
- Throughput: at most one command per 2 cycles (issue, then IDLE arbitrate).
- Read return: fetch_rvalid=1 one cycle after the acceptance cycle; fetch_rdata = ISP_DataRdValue sampled in that cycle. fetch_rdata holds until the next rvalid.
- Strobe exclusivity: ISP_RdStr and ISP_DataWrStr are never both 1. ISP_DataTagValue = 0 for reads.
- starve_cnt: increments (saturating at STARVE_LIMIT) in each IDLE arbitration where ext_valid=1 and ext loses. Clears on ext win or ext_valid=0.
- Requester rules: requesters hold addr/data stable until their ack. Dropping fetch_req before fetch_gnt is legal only while not yet granted. The block does not check this.
- Simultaneous: fetch_req and ext_valid in the same IDLE cycle with starve_cnt<LIMIT → fetch wins and starve_cnt+1.
- fetch_rvalid may coincide with the next command's issue cycle.

Test Plan:
- Single fetch, addr 0x00010, no stall → RdStr=1 on cycle+1, fetch_gnt same cycle, fetch_rvalid cycle+2 with data 0xDEADBEEF from model; isp_busy 1 for exactly 1 cycle.
- icop write 0x12345678 to 0x00020, cpz_spram=1, ISP_Stall high 3 cycles → DataWrStr/addr/data stable 4 cycles, icop_ack on 4th; with cpz_spram=0 → ack next cycle, no strobe.
- fetch_req held continuously plus ext_valid, STARVE_LIMIT=4 → fetch wins 4 IDLE arbitrations, ext wins the 5th, starve_cnt returns to 0.
- isp_size=2 (8 KB), ext_addr[19:12]=0x02 → ext_ready=ext_err=1, no strobe; ext_addr[19:12]=0x01 → write issued, ext_err=0.
- icop_req, ext_valid and fetch_req all high in the same cycle → order icop, fetch, ext (starve_cnt<LIMIT), with no overlap of strobes.
- greset asserted in CMD during ISP_Stall → next cycle all strobes 0, no fetch_rvalid/ack, state IDLE, starve_cnt 0.
